// File: rtl/sharpen_frame_ctrl_pkg.sv
// Shared definitions for the sharpen frame controller.
//   - register map addresses on the 2-bit control bus
//   - bit positions inside CTRL and STATUS
//   - frame FSM state encoding
//   - helper that packs the STATUS read word
package sharpen_frame_ctrl_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_THRESH = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_FCNT   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_GAIN_LSB = 1;

  localparam int STAT_LINE_ERR_BIT  = 0;
  localparam int STAT_FRAME_ERR_BIT = 1;
  localparam int STAT_BUSY_BIT      = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } frame_state_t;

  // STATUS word: sticky line/frame errors plus the live busy flag, upper bits zero.
  function automatic logic [15:0] status_word(input logic line_err,
                                              input logic frame_err,
                                              input logic busy);
    logic [15:0] w;
    w = '0;
    w[STAT_LINE_ERR_BIT]  = line_err;
    w[STAT_FRAME_ERR_BIT] = frame_err;
    w[STAT_BUSY_BIT]      = busy;
    return w;
  endfunction

endpackage

// File: rtl/sharpen_cfg_regs.sv
// Configuration register file for the sharpen frame controller.
// Holds the CTRL/THRESH shadow registers, the per-frame active copies,
// the sticky STATUS error bits and the completed-frame counter, and
// serves registered reads on the control bus.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_cfg_wr/i_cfg_rd/i_cfg_addr     bus strobes and register address
//   i_cfg_wdata, o_cfg_rdata         write data, registered read data
//   i_load_act                       frame start: copy shadow into active
//   i_line_err_set, i_frame_err_set  sticky error set pulses
//   i_busy                           live frame-busy flag for STATUS
//   i_frame_inc                      frame completed: bump FRAME_CNT
//   o_act_en/o_act_gain/o_act_thresh active per-frame settings
module sharpen_cfg_regs
  import sharpen_frame_ctrl_pkg::*;
#(
  parameter int GAIN_W = 3,
  parameter int TH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cfg_wr,
  input  logic              i_cfg_rd,
  input  logic [1:0]        i_cfg_addr,
  input  logic [15:0]       i_cfg_wdata,
  output logic [15:0]       o_cfg_rdata,
  input  logic              i_load_act,
  input  logic              i_line_err_set,
  input  logic              i_frame_err_set,
  input  logic              i_busy,
  input  logic              i_frame_inc,
  output logic              o_act_en,
  output logic [GAIN_W-1:0] o_act_gain,
  output logic [TH_W-1:0]   o_act_thresh
);

  logic [GAIN_W:0]     r_ctrl, w_ctrl_next;
  logic [TH_W-1:0]     r_thresh, w_thresh_next;
  logic                r_line_err, w_line_err_next;
  logic                r_frame_err, w_frame_err_next;
  logic [15:0]         r_frame_cnt;
  logic [15:0]         r_rdata, w_rdata_next;
  logic                r_act_en;
  logic [GAIN_W-1:0]   r_act_gain;
  logic [TH_W-1:0]     r_act_thresh;
  logic                w_wr_ctrl, w_wr_thresh, w_wr_status;
  logic                w_unused_wdata;

  assign w_wr_ctrl   = i_cfg_wr && (i_cfg_addr == ADDR_CTRL);
  assign w_wr_thresh = i_cfg_wr && (i_cfg_addr == ADDR_THRESH);
  assign w_wr_status = i_cfg_wr && (i_cfg_addr == ADDR_STATUS);

  // Only the low field bits of each register are stored.
  assign w_unused_wdata = ^i_cfg_wdata;

  // Next shadow values. The active copy loads from these so that a write
  // landing on the frame-start cycle is taken by that frame.
  always_comb begin
    w_ctrl_next   = r_ctrl;
    w_thresh_next = r_thresh;
    if (w_wr_ctrl)   w_ctrl_next   = i_cfg_wdata[GAIN_W:0];
    if (w_wr_thresh) w_thresh_next = i_cfg_wdata[TH_W-1:0];
  end

  // Sticky errors: write-1-to-clear, but a set in the same cycle wins.
  always_comb begin
    w_line_err_next  = r_line_err;
    w_frame_err_next = r_frame_err;
    if (w_wr_status && i_cfg_wdata[STAT_LINE_ERR_BIT])  w_line_err_next  = 1'b0;
    if (w_wr_status && i_cfg_wdata[STAT_FRAME_ERR_BIT]) w_frame_err_next = 1'b0;
    if (i_line_err_set)  w_line_err_next  = 1'b1;
    if (i_frame_err_set) w_frame_err_next = 1'b1;
  end

  // Read mux reflects register contents before any same-cycle write.
  always_comb begin
    w_rdata_next = '0;
    case (i_cfg_addr)
      ADDR_CTRL:   w_rdata_next = 16'(r_ctrl);
      ADDR_THRESH: w_rdata_next = 16'(r_thresh);
      ADDR_STATUS: w_rdata_next = status_word(r_line_err, r_frame_err, i_busy);
      default:     w_rdata_next = r_frame_cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl       <= '0;
      r_thresh     <= '0;
      r_line_err   <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
      r_rdata      <= '0;
      r_act_en     <= 1'b0;
      r_act_gain   <= '0;
      r_act_thresh <= '0;
    end else begin
      r_ctrl      <= w_ctrl_next;
      r_thresh    <= w_thresh_next;
      r_line_err  <= w_line_err_next;
      r_frame_err <= w_frame_err_next;
      if (i_load_act) begin
        r_act_en     <= w_ctrl_next[CTRL_EN_BIT];
        r_act_gain   <= w_ctrl_next[CTRL_GAIN_LSB +: GAIN_W];
        r_act_thresh <= w_thresh_next;
      end
      if (i_frame_inc) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (i_cfg_rd)    r_rdata     <= w_rdata_next;
    end
  end

  assign o_cfg_rdata  = r_rdata;
  assign o_act_en     = r_act_en;
  assign o_act_gain   = r_act_gain;
  assign o_act_thresh = r_act_thresh;

endmodule

// File: rtl/sharpen_frame_ctrl.sv
// Frame-level controller for the sharpen pipeline.
// Watches the pre-image sync/valid stream, tracks pixel position, checks
// frame geometry against H_DISP x V_DISP and hands per-frame settings to
// the datapath through the register file in sharpen_cfg_regs.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   pre_img_vsync/hsync/valid        incoming stream syncs (hsync unused)
//   cfg_wr/cfg_rd/cfg_addr/cfg_wdata control bus, cfg_rdata registered
//   act_en/act_gain/act_thresh       settings latched at frame start
//   pix_x/pix_y                      position of the last valid pixel
//   frame_busy/frame_done/frame_ok   frame status
module sharpen_frame_ctrl
  import sharpen_frame_ctrl_pkg::*;
#(
  parameter int H_DISP = 1280,
  parameter int V_DISP = 720,
  parameter int CNT_W  = 11,
  parameter int GAIN_W = 3,
  parameter int TH_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pre_img_vsync,
  input  logic              pre_img_hsync,
  input  logic              pre_img_valid,
  input  logic              cfg_wr,
  input  logic              cfg_rd,
  input  logic [1:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  output logic [15:0]       cfg_rdata,
  output logic              act_en,
  output logic [GAIN_W-1:0] act_gain,
  output logic [TH_W-1:0]   act_thresh,
  output logic [CNT_W-1:0]  pix_x,
  output logic [CNT_W-1:0]  pix_y,
  output logic              frame_busy,
  output logic              frame_done,
  output logic              frame_ok
);

  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(H_DISP - 1);
  localparam logic [CNT_W-1:0] Y_FULL = CNT_W'(V_DISP);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  frame_state_t     r_state, w_state_next;
  logic             r_vsync_d, r_valid_d, r_start_pend, r_frame_bad;
  logic [CNT_W-1:0] r_x, r_y, r_pix_x, r_pix_y;
  logic             w_vs_rise, w_vs_fall, w_valid_fall;
  logic             w_active, w_pix_valid, w_line_short, w_y_over, w_frame_good;
  logic             w_frame_start, w_busy, w_frame_done, w_frame_ok;
  logic             w_line_err_set, w_frame_err_set;
  logic             w_unused;

  // hsync is only observed; line boundaries come from valid edges.
  assign w_unused = pre_img_hsync;

  assign w_vs_rise    = pre_img_vsync & ~r_vsync_d;
  assign w_vs_fall    = ~pre_img_vsync & r_vsync_d;
  assign w_valid_fall = r_valid_d & ~pre_img_valid;

  assign w_active     = (r_state == ST_ACTIVE);
  assign w_pix_valid  = w_active & pre_img_valid;
  // A line that stops before wrapping leaves x non-zero when valid drops.
  assign w_line_short = w_active & w_valid_fall & (r_x != '0);
  // Any pixel after the last full line overflows the frame.
  assign w_y_over     = w_pix_valid & (r_y == Y_FULL);
  assign w_frame_good = (r_y == Y_FULL) && (r_x == '0) && !r_frame_bad;

  assign w_line_err_set  = w_line_short;
  assign w_frame_err_set = w_line_short | w_y_over | (w_frame_done & ~w_frame_good);

  // Edge history. vsync history resets high so a vsync already asserted
  // when reset lifts does not count as a frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d    <= 1'b1;
      r_valid_d    <= 1'b0;
      r_start_pend <= 1'b0;
    end else begin
      r_vsync_d <= pre_img_vsync;
      r_valid_d <= pre_img_valid;
      // A rise during the DONE cycle is held so IDLE can take it next cycle.
      if (r_state == ST_IDLE) begin
        r_start_pend <= 1'b0;
      end else if ((r_state == ST_DONE) && w_vs_rise) begin
        r_start_pend <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_vs_rise || r_start_pend) w_state_next = ST_ACTIVE;
      ST_ACTIVE: if (w_vs_fall) w_state_next = ST_DONE;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_frame_start = 1'b0;
    w_busy        = 1'b0;
    w_frame_done  = 1'b0;
    w_frame_ok    = 1'b0;
    case (r_state)
      ST_IDLE:   w_frame_start = w_vs_rise || r_start_pend;
      ST_ACTIVE: w_busy = 1'b1;
      ST_DONE: begin
        w_frame_done = 1'b1;
        w_frame_ok   = w_frame_good;
      end
      default: ;
    endcase
  end

  // Position counters and reported pixel coordinates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x         <= '0;
      r_y         <= '0;
      r_pix_x     <= '0;
      r_pix_y     <= '0;
      r_frame_bad <= 1'b0;
    end else begin
      if (w_frame_start) begin
        r_x         <= '0;
        r_y         <= '0;
        r_frame_bad <= 1'b0;
      end else if (w_active) begin
        if (pre_img_valid) begin
          r_pix_x <= r_x;
          r_pix_y <= r_y;
          if (r_x == X_LAST) begin
            r_x <= '0;
            if (r_y != Y_FULL) r_y <= r_y + ONE;
          end else begin
            r_x <= r_x + ONE;
          end
        end else if (w_line_short) begin
          r_x <= '0;
        end
        if (w_line_short || w_y_over) r_frame_bad <= 1'b1;
      end
    end
  end

  sharpen_cfg_regs #(
    .GAIN_W (GAIN_W),
    .TH_W   (TH_W)
  ) u_cfg_regs (
    .clk             (clk),
    .rst             (rst),
    .i_cfg_wr        (cfg_wr),
    .i_cfg_rd        (cfg_rd),
    .i_cfg_addr      (cfg_addr),
    .i_cfg_wdata     (cfg_wdata),
    .o_cfg_rdata     (cfg_rdata),
    .i_load_act      (w_frame_start),
    .i_line_err_set  (w_line_err_set),
    .i_frame_err_set (w_frame_err_set),
    .i_busy          (w_busy),
    .i_frame_inc     (w_frame_done),
    .o_act_en        (act_en),
    .o_act_gain      (act_gain),
    .o_act_thresh    (act_thresh)
  );

  assign pix_x      = r_pix_x;
  assign pix_y      = r_pix_y;
  assign frame_busy = w_busy;
  assign frame_done = w_frame_done;
  assign frame_ok   = w_frame_ok;

endmodule
